// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen-state enum, match defaults and score helper
package game_pkg;

    typedef enum logic [2:0] {
        START   = 3'd0,
        SHOOTER = 3'd1,
        KEEPER  = 3'd2,
        WINNER  = 3'd3,
        LOSER   = 3'd4
    } g_state;

    localparam int ROUNDS_DEFAULT     = 5;
    localparam int END_FRAMES_DEFAULT = 300;

    // Score counters stick at 15 rather than wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - 1-bit registered rising-edge detector
// Ports: clk, rst (sync, active-high), d (level in), rise (high while d=1 and d was 0 last cycle)
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic d_d;

    always_comb begin
        d_d = d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - penalty-match screen sequencer with frame-aligned state changes
// Ports: clk, rst (sync, active-high), vblnk (frame tick on its rise), btn_start (level),
//        round_done/player_scored (shot result), game_state, player_score, cpu_score,
//        round_idx, state_changed (one-cycle pulse when game_state updates)
module screen_sequencer
    import game_pkg::*;
#(
    parameter int ROUNDS     = ROUNDS_DEFAULT,
    parameter int END_FRAMES = END_FRAMES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       btn_start,
    input  logic       round_done,
    input  logic       player_scored,
    output g_state     game_state,
    output logic [3:0] player_score,
    output logic [3:0] cpu_score,
    output logic [3:0] round_idx,
    output logic       state_changed
);

    localparam logic [3:0] LAST_ROUND = 4'(2 * ROUNDS);
    localparam logic [9:0] END_CNT    = 10'(END_FRAMES);

    logic frame_tick;
    logic btn_rise;

    rise_detect u_vblnk_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (vblnk),
        .rise (frame_tick)
    );

    rise_detect u_btn_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (btn_start),
        .rise (btn_rise)
    );

    g_state     state_q, state_d;
    g_state     pend_state_q, pend_state_d;
    logic       pending_q, pending_d;
    logic [3:0] p_score_q, p_score_d;
    logic [3:0] c_score_q, c_score_d;
    logic [3:0] round_q, round_d;
    logic [9:0] frame_cnt_q, frame_cnt_d;
    logic       changed_q, changed_d;

    logic [3:0] round_inc;
    logic [3:0] c_score_new;
    logic [9:0] cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= START;
            pend_state_q <= START;
            pending_q    <= 1'b0;
            p_score_q    <= 4'd0;
            c_score_q    <= 4'd0;
            round_q      <= 4'd0;
            frame_cnt_q  <= 10'd0;
            changed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_state_q <= pend_state_d;
            pending_q    <= pending_d;
            p_score_q    <= p_score_d;
            c_score_q    <= c_score_d;
            round_q      <= round_d;
            frame_cnt_q  <= frame_cnt_d;
            changed_q    <= changed_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_state_d = pend_state_q;
        pending_d    = pending_q;
        p_score_d    = p_score_q;
        c_score_d    = c_score_q;
        round_d      = round_q;
        frame_cnt_d  = frame_cnt_q;
        changed_d    = 1'b0;

        round_inc   = (round_q >= LAST_ROUND) ? LAST_ROUND : round_q + 4'd1;
        c_score_new = player_scored ? c_score_q : sat_inc4(c_score_q);
        cnt_inc     = frame_cnt_q + 10'd1;

        if (pending_q) begin
            // While a decision waits for the frame boundary, every new event is
            // dropped so the pended screen can never be overwritten.
            if (frame_tick) begin
                state_d   = pend_state_q;
                pending_d = 1'b0;
                changed_d = 1'b1;
                if (pend_state_q == WINNER || pend_state_q == LOSER) begin
                    frame_cnt_d = 10'd0;
                end
            end
        end else begin
            case (state_q)
                START: begin
                    if (btn_rise) begin
                        pending_d    = 1'b1;
                        pend_state_d = SHOOTER;
                        p_score_d    = 4'd0;
                        c_score_d    = 4'd0;
                        round_d      = 4'd0;
                    end
                end
                SHOOTER: begin
                    if (round_done) begin
                        if (player_scored) begin
                            p_score_d = sat_inc4(p_score_q);
                        end
                        round_d      = round_inc;
                        pending_d    = 1'b1;
                        pend_state_d = KEEPER;
                    end
                end
                KEEPER: begin
                    if (round_done) begin
                        c_score_d = c_score_new;
                        round_d   = round_inc;
                        pending_d = 1'b1;
                        // The final verdict includes this shot; a tie goes to the CPU.
                        if (round_inc >= LAST_ROUND) begin
                            pend_state_d = (p_score_q > c_score_new) ? WINNER : LOSER;
                        end else begin
                            pend_state_d = SHOOTER;
                        end
                    end
                end
                WINNER, LOSER: begin
                    if (btn_rise) begin
                        pending_d    = 1'b1;
                        pend_state_d = START;
                    end else if (frame_tick) begin
                        frame_cnt_d = cnt_inc;
                        if (cnt_inc >= END_CNT) begin
                            pending_d    = 1'b1;
                            pend_state_d = START;
                        end
                    end
                end
                default: begin
                    pending_d    = 1'b1;
                    pend_state_d = START;
                end
            endcase
        end
    end

    assign game_state    = state_q;
    assign player_score  = p_score_q;
    assign cpu_score     = c_score_q;
    assign round_idx     = round_q;
    assign state_changed = changed_q;

endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 Parameter ROUNDS, default 5, shots per side in one match (1..7).
REQ-002 Parameter END_FRAMES, default 300, frames the WINNER/LOSER screen is held (1..1023).
REQ-003 clk  input  1  system/pixel clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 vblnk  input  1  vertical blanking from the timing chain; its rising edge defines frame_tick.
REQ-006 btn_start  input  1  start button, already synchronised and debounced, level.
REQ-007 round_done  input  1  one-cycle pulse: current shot resolved.
REQ-008 player_scored  input  1  valid with round_done; 1 = outcome favours the player.
REQ-009 game_state  output  g_state  screen selection consumed by the screen selector.
REQ-010 player_score, cpu_score  output  4 each  match scores.
REQ-011 round_idx  output  4  rounds completed in the current match (0..2*ROUNDS).
REQ-012 state_changed  output  1  one-cycle pulse in the cycle game_state updates.

Function
REQ-013 States: START, SHOOTER, KEEPER, WINNER, LOSER (g_state enum); game_state is registered.
REQ-014 frame_tick = vblnk high this cycle and low the previous cycle; game_state SHALL only change in a frame_tick cycle.
REQ-015 Each decided transition loads next_state into a pending register (pending=1); applied at the next frame_tick, which clears pending and pulses state_changed.
REQ-016 START: rising edge of btn_start -> pending SHOOTER; scores and round_idx cleared in the same cycle.
REQ-017 SHOOTER: round_done -> player_score+1 if player_scored; round_idx+1; pending KEEPER.
REQ-018 KEEPER: round_done -> cpu_score+1 if NOT player_scored; round_idx+1; pending SHOOTER, unless round_idx reaches 2*ROUNDS, then pending WINNER if player_score>cpu_score else LOSER (tie -> LOSER).
REQ-019 Final comparison uses scores including the current round's update.
REQ-020 WINNER/LOSER: frame counter (10 bit) cleared on entry, incremented per frame_tick; at END_FRAMES -> pending START; btn_start rising edge -> pending START immediately.
REQ-021 round_done while pending=1, or in START/WINNER/LOSER: ignored, no counter change.
REQ-022 btn_start edges outside START/WINNER/LOSER: ignored.
REQ-023 A second decision while pending=1 SHALL NOT overwrite the pending state.
REQ-024 Decision and frame_tick in the same cycle: decision is pended, applied at the following frame_tick.
REQ-025 Scores saturate at 15; round_idx never exceeds 2*ROUNDS.

Reset
REQ-026 On rst: game_state=START, scores=0, round_idx=0, pending=0, frame counter=0, state_changed=0, edge-detect registers=0.
REQ-027 rst mid-match or with a transition pending discards all progress; no state_changed pulse on exit from reset.

Structure
REQ-028 g_state enum stays in game_pkg; ROUNDS and END_FRAMES defaults added there as constants.
REQ-029 One sub-module, rise_detect (1-bit registered rising-edge detector), instantiated for vblnk and btn_start.

Verification
REQ-030 Reset, 3 frames, no input -> game_state=START, state_changed never pulses.
REQ-031 btn_start edge mid-frame -> game_state stays START until next vblnk rise, then SHOOTER with one state_changed pulse; scores 0.
REQ-032 ROUNDS=5; 10 round_done pulses (one per frame), player_scored=1 all -> player 5, cpu 0, round_idx 10, WINNER one frame after last pulse.
REQ-033 Alternating outcomes ending 2-2 after ROUNDS=2 -> LOSER; after END_FRAMES=4 frame_ticks -> START.
REQ-034 Two round_done pulses within one frame -> only first counted; round_idx +1.
REQ-035 rst asserted with KEEPER pending, scores 3-1 -> START, scores 0, no late transition on next frame_tick.
